stage_sequencer: RTL
====================

# stage_sequencer

Multi-cycle control FSM for the RISC-V core. It issues one-cycle enable pulses to the fetch, decode, execute, memory and write stages in order, and waits for each stage's completion level before moving on. It skips the memory stage for non-memory instructions, counts retired instructions, honours halt requests at instruction boundaries, and traps on a stage that never completes. It sits at core top level and is the sole driver of every stage `enabled` input.

## Interface
- `TIMEOUT`, 1024: maximum cycles a stage may take, from its enable pulse to accepted done, before ERROR.
- `CNT_W`, 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset: synchronous, active-low.
- `start`  in  1  leave IDLE/HALTED and begin fetching.
- `halt_req`  in  1  stop after the current instruction retires.
- `f_done`, `d_done`, `e_done`, `m_done`, `w_done`  in  1 each  stage completion levels.
- `need_mem`  in  1  decode result; qualified only in the cycle `d_done` is accepted.
- `f_en`, `d_en`, `e_en`, `m_en`, `w_en`  out  1 each  stage enable pulses.
- `running`  out  1  high in states F/D/E/M/W.
- `retired`  out  1  one-cycle pulse per retired instruction.
- `instret`  out  CNT_W  retired count.
- `timeout`  out  1  sticky error flag.
- `cur_state`  out  3  FSM state, for debug.

## Operation
- States: IDLE, F, D, E, M, W, HALTED, ERROR. All outputs are registered.
- Stage states (F, D, E, M, W):
  - The stage enable is high only in the first cycle in the state.
  - The stage done is sampled from the second cycle onward. A done that is high in the enable cycle is ignored, because stages drop done while enabled.
- Transitions on accepted done:
  - F → D.
  - D → M if `need_mem` = 1, else D → E.
  - M → E.
  - E → W.
  - W → F, or W → HALTED if the halt latch is set.
- IDLE or HALTED with `start` = 1 → F. This clears the halt latch.
- `halt_req`:
  - Latched on any cycle while `running` = 1.
  - Also latched if it is asserted together with `start` in IDLE or HALTED; exactly one instruction then executes before HALTED.
  - Ignored otherwise.
- Retire:
  - On accepted `w_done`, `retired` = 1 for the next cycle only.
  - `instret` increments at the same edge and wraps modulo 2^CNT_W.
- Wait counter:
  - Cleared on every stage entry; counts cycles spent in the state.
  - If it reaches TIMEOUT−1 without an accepted done → ERROR.
  - A done arriving in that same cycle wins: normal transition, no error.
- ERROR:
  - All enables low, `running` = 0, `timeout` = 1.
  - Exits only on reset; `start` is ignored.

## Timing
- Reset values: all `*_en` 0, `running` 0, `retired` 0, `instret` 0, `timeout` 0, `cur_state` = IDLE, halt latch 0, wait counter 0.
- Reset mid-instruction: the next edge forces the reset values. An enable pulse in progress is not completed.
- Latencies are measured from the edge that samples `start`, taken as edge k:
  - `f_en` is high in cycle k+1.
  - With every done returned at the earliest point: a non-mem instruction has `w_en` in cycle k+7.
  - `retired` and the next `f_en` are both high in cycle k+9.
  - Minimum cost is 8 cycles for a non-mem instruction and 10 cycles with memory.
- Each enable is exactly one cycle wide. No two enables are ever high in the same cycle.

## Structure
- Shared package `def.sv`:
  - `typedef enum logic [2:0] seq_state_t` with encodings IDLE=0, F=1, D=2, E=3, M=4, W=5, HALTED=6, ERROR=7.
  - Default TIMEOUT constant.
- One sub-module, `stage_timer`: the wait counter, with clear and count inputs and an `expired` output.

## Test plan
- Reset then `start`, all dones returned at the earliest point, `need_mem` = 0:
  - enables in order F, D, E, W at cycles k+1, k+3, k+5, k+7.
  - `retired` at k+9; `instret` = 1.
- `need_mem` = 1 with `m_done` delayed 5 cycles:
  - order F, D, M, E, W.
  - `e_en` is 6 cycles after `m_en`.
  - `instret` increments once.
- `halt_req` pulsed during E of instruction 3:
  - W retires it (`instret` = 3) → HALTED, `running` = 0.
  - A later `start` resumes at F.
- `f_done` never asserted, TIMEOUT = 16:
  - ERROR with `timeout` = 1 at 16 cycles after `f_en`.
  - A subsequent `start` has no effect.
  - `rstn` low clears to IDLE.
- Done arriving exactly at TIMEOUT−1: normal transition, `timeout` stays 0.
- `CNT_W` = 4, 16 instructions: `instret` wraps 15 → 0.
- `rstn` low during W: next cycle all outputs at reset values, `instret` = 0.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared types and defaults for the stage sequencer: state encoding,
// default parameters and a stage-state predicate.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_F      = 3'd1,
    ST_D      = 3'd2,
    ST_E      = 3'd3,
    ST_M      = 3'd4,
    ST_W      = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERROR  = 3'd7
  } seq_state_t;

  localparam int DEFAULT_TIMEOUT = 1024;
  localparam int DEFAULT_CNT_W   = 64;

  // True in the five states that own a pipeline stage.
  function automatic logic is_stage(input seq_state_t s);
    case (s)
      ST_F, ST_D, ST_E, ST_M, ST_W: is_stage = 1'b1;
      default:                      is_stage = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage_sequencer_timer.sv
// Per-stage wait counter: cleared on stage entry, counts cycles spent in
// the stage and flags when the last permitted cycle has been reached.
module stage_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt;

  // Clear has priority so a new stage always starts at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + TW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM: pulses each stage enable in turn, waits for the
// stage done, skips memory for non-memory instructions, retires and halts.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             halt_req,
  input  logic             f_done,
  input  logic             d_done,
  input  logic             e_done,
  input  logic             m_done,
  input  logic             w_done,
  input  logic             need_mem,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             running,
  output logic             retired,
  output logic [CNT_W-1:0] instret,
  output logic             timeout,
  output logic [2:0]       cur_state
);

  seq_state_t state, state_nx;
  logic       halt_latch, halt_nx;
  logic       first, stage_done, accepted, enter, retire, expired;

  // An enable is high exactly in the first cycle of a stage state.
  assign first = f_en | d_en | e_en | m_en | w_en;

  stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (enter),
    .count   (is_stage(state)),
    .expired (expired)
  );

  // Next-state, halt latch and retire decode.
  always_comb begin
    state_nx   = state;
    halt_nx    = halt_latch;
    enter      = 1'b0;
    retire     = 1'b0;
    stage_done = 1'b0;

    case (state)
      ST_F:    stage_done = f_done;
      ST_D:    stage_done = d_done;
      ST_E:    stage_done = e_done;
      ST_M:    stage_done = m_done;
      ST_W:    stage_done = w_done;
      default: stage_done = 1'b0;
    endcase
    // Done seen in the enable cycle is stale and must not advance the stage.
    accepted = stage_done & ~first;

    if (is_stage(state) && halt_req) begin
      halt_nx = 1'b1;
    end else begin
      halt_nx = halt_latch;
    end

    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_nx = ST_F;
          enter    = 1'b1;
          halt_nx  = halt_req;
        end else begin
          state_nx = state;
        end
      end
      ST_F: begin
        if (accepted) begin
          state_nx = ST_D;
          enter    = 1'b1;
        end else if (expired) begin
          state_nx = ST_ERROR;
        end else begin
          state_nx = state;
        end
      end
      ST_D: begin
        if (accepted) begin
          state_nx = need_mem ? ST_M : ST_E;
          enter    = 1'b1;
        end else if (expired) begin
          state_nx = ST_ERROR;
        end else begin
          state_nx = state;
        end
      end
      ST_M: begin
        if (accepted) begin
          state_nx = ST_E;
          enter    = 1'b1;
        end else if (expired) begin
          state_nx = ST_ERROR;
        end else begin
          state_nx = state;
        end
      end
      ST_E: begin
        if (accepted) begin
          state_nx = ST_W;
          enter    = 1'b1;
        end else if (expired) begin
          state_nx = ST_ERROR;
        end else begin
          state_nx = state;
        end
      end
      ST_W: begin
        if (accepted) begin
          retire = 1'b1;
          if (halt_latch) begin
            state_nx = ST_HALTED;
          end else begin
            state_nx = ST_F;
            enter    = 1'b1;
          end
        end else if (expired) begin
          state_nx = ST_ERROR;
        end else begin
          state_nx = state;
        end
      end
      ST_ERROR: state_nx = ST_ERROR;
      default:  state_nx = ST_ERROR;
    endcase
  end

  // State, halt latch and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      halt_latch <= 1'b0;
      f_en       <= 1'b0;
      d_en       <= 1'b0;
      e_en       <= 1'b0;
      m_en       <= 1'b0;
      w_en       <= 1'b0;
      running    <= 1'b0;
      retired    <= 1'b0;
      timeout    <= 1'b0;
      instret    <= '0;
    end else begin
      state      <= state_nx;
      halt_latch <= halt_nx;
      f_en       <= enter && (state_nx == ST_F);
      d_en       <= enter && (state_nx == ST_D);
      e_en       <= enter && (state_nx == ST_E);
      m_en       <= enter && (state_nx == ST_M);
      w_en       <= enter && (state_nx == ST_W);
      running    <= is_stage(state_nx);
      retired    <= retire;
      timeout    <= (state_nx == ST_ERROR);
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end else begin
        instret <= instret;
      end
    end
  end

  assign cur_state = state;

endmodule
